// File: rtl/scroll_add_sched_if.sv
// Request, result and adder-slice bundle for scroll_add_sched.
// slave = scheduler side, master = requesters/consumer/adder side.
interface scroll_add_sched_if #(
  parameter int WIDTH = 12
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ci;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ci;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_ci;
  logic [3:0]       add_s;
  logic             add_co;
  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic [WIDTH-1:0] res_sum;
  logic             res_co;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ci,
    input  req1_valid, req1_a, req1_b, req1_ci,
    output req0_ready, req1_ready,
    output add_a, add_b, add_ci,
    input  add_s, add_co,
    output res_valid, res_id, res_sum, res_co,
    input  res_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ci,
    output req1_valid, req1_a, req1_b, req1_ci,
    input  req0_ready, req1_ready,
    input  add_a, add_b, add_ci,
    output add_s, add_co,
    input  res_valid, res_id, res_sum, res_co,
    output res_ready
  );
endinterface

// File: rtl/scroll_add_sched.sv
// Two-requester add sequencer: one nibble per clock through a shared
// 4-bit adder slice, carry chained in a register.
// Ports: clk, nRES (async active-low), bus (scroll_add_sched_if.slave):
//   req0/req1 valid/ready/a/b/ci, add_a/b/ci out, add_s/co in,
//   res_valid/ready/id/sum/co.
// Macro ADD_SCHED_FIXED_PRIO_EN: req0 fixed priority instead of
// round-robin.
module scroll_add_sched #(
  parameter int WIDTH = 12
) (
  input logic             clk,
  input logic             nRES,
  scroll_add_sched_if.slave bus
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [KW-1:0]    k;
  logic             c;
  logic             id;
  logic             gnt;
  logic             acc;
  logic             idle;
  logic             run;
  logic             last_step;

  assign idle      = (state == IDLE);
  assign run       = (state == RUN);
  assign last_step = (k == K_LAST);

  // gnt: 0 selects req0, 1 selects req1
`ifdef ADD_SCHED_FIXED_PRIO_EN
  assign gnt = ~bus.req0_valid;
`else
  logic last_grant;
  assign gnt = bus.req0_valid
             ? (bus.req1_valid & ~last_grant)
             : 1'b1;
`endif

  // ready is forced low while reset is held
  assign bus.req0_ready = nRES & idle
                        & bus.req0_valid & ~gnt;
  assign bus.req1_ready = nRES & idle
                        & bus.req1_valid & gnt;
  assign acc = bus.req0_ready | bus.req1_ready;

  assign bus.add_a  = run ? 4'(a_q >> {k, 2'b00}) : 4'h0;
  assign bus.add_b  = run ? 4'(b_q >> {k, 2'b00}) : 4'h0;
  assign bus.add_ci = run & c;

  assign bus.res_valid = (state == DONE);
  assign bus.res_sum   = sum_q;
  assign bus.res_co    = c;
  assign bus.res_id    = id;

  always_comb begin
    state_d = state;
    unique case (1'b1)
      (state == IDLE): if (acc) state_d = RUN;
      (state == RUN):  if (last_step) state_d = DONE;
      (state == DONE): if (bus.res_ready) state_d = IDLE;
      default:         state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRES) begin
    if (!nRES) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      k     <= '0;
      c     <= 1'b0;
      id    <= 1'b0;
    end else begin
      state <= state_d;
      if (acc) begin
        a_q   <= gnt ? bus.req1_a : bus.req0_a;
        b_q   <= gnt ? bus.req1_b : bus.req0_b;
        c     <= gnt ? bus.req1_ci : bus.req0_ci;
        id    <= gnt;
        k     <= '0;
        sum_q <= '0;
      end else if (run) begin
        // sum was cleared on accept, so OR-in places the nibble
        sum_q <= sum_q
               | (WIDTH'(bus.add_s) << {k, 2'b00});
        c     <= bus.add_co;
        k     <= last_step ? '0 : k + 1'b1;
      end
    end
  end

`ifndef ADD_SCHED_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge nRES) begin
    if (!nRES) begin
      last_grant <= 1'b1;
    end else if (acc) begin
      last_grant <= gnt;
    end
  end
`endif

endmodule

// File: tb/tb_scroll_add_sched.sv
// Self-checking bench for scroll_add_sched (WIDTH=12).
// Adder slice modelled behaviourally; results checked against a+b+ci.
module tb_scroll_add_sched;

  localparam int W = 12;
  localparam int N = W / 4;

  logic clk;
  logic nRES;
  int   n_cmp;
  int   n_err;
  int   n_acc;
  int   n_res;
  bit   lg;

  scroll_add_sched_if #(.WIDTH(W)) bus ();

  assign {bus.add_co, bus.add_s} =
    5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_ci);

  scroll_add_sched #(.WIDTH(W)) dut (
    .clk  (clk),
    .nRES (nRES),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input bit r,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input bit ci);
    bit acc;
    acc = 1'b0;
    if (r) begin
      bus.req1_a = a; bus.req1_b = b;
      bus.req1_ci = ci; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_a = a; bus.req0_b = b;
      bus.req0_ci = ci; bus.req0_valid = 1'b1;
    end
    for (int i = 0; i < 12 && !acc; i++) begin
      #1;
      acc = r ? bus.req1_ready : bus.req0_ready;
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("accept", 32'(acc), 32'd1);
    if (acc) begin
      lg = r;
      n_acc++;
    end
  endtask

  task automatic wait_result(input bit r,
                             input logic [W-1:0] a,
                             input logic [W-1:0] b,
                             input bit ci,
                             input bit take);
    logic [W:0] e;
    int cnt;
    int j;
    int m;
    int cj;
    e = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    cnt = 1;
    while (!bus.res_valid && cnt < 20) begin
      if (cnt <= N) begin
        j  = cnt - 1;
        m  = (1 << (4 * j)) - 1;
        cj = ((int'(a) & m) + (int'(b) & m) + int'(ci))
             >> (4 * j);
        chk("nib_a", 32'(bus.add_a), (int'(a) >> (4 * j)) & 15);
        chk("nib_b", 32'(bus.add_b), (int'(b) >> (4 * j)) & 15);
        chk("nib_ci", 32'(bus.add_ci), cj);
      end
      @(negedge clk);
      cnt++;
    end
    chk("res_valid", 32'(bus.res_valid), 32'd1);
    chk("latency", cnt, N + 1);
    chk("res_sum", 32'(bus.res_sum), 32'(e[W-1:0]));
    chk("res_co", 32'(bus.res_co), 32'(e[W]));
    chk("res_id", 32'(bus.res_id), 32'(r));
    if (bus.res_valid) n_res++;
    if (take) begin
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      chk("res_taken", 32'(bus.res_valid), 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit           rc;
    bit           rr;
    bit           g;
    bit           eg;
    bit           first;
    int           lastt;
    int           ng;
    int           sp;
    bit           qi[$];
    logic [W:0]   qs[$];
    logic [W:0]   s0;
    logic [W:0]   s1;

    n_cmp = 0; n_err = 0; n_acc = 0; n_res = 0;
    lg = 1'b1;
    nRES = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = '0;
    bus.req0_b = '0; bus.req0_ci = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = '0;
    bus.req1_b = '0; bus.req1_ci = 1'b0;
    bus.res_ready = 1'b0;

    #2;
    chk("rst_ready0", 32'(bus.req0_ready), 0);
    chk("rst_ready1", 32'(bus.req1_ready), 0);
    chk("rst_valid", 32'(bus.res_valid), 0);
    chk("rst_sum", 32'(bus.res_sum), 0);
    chk("rst_co_id", {bus.res_co, bus.res_id}, 0);
    chk("rst_add",
        {bus.add_a, bus.add_b, bus.add_ci}, 0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    nRES = 1'b1;
    @(negedge clk);

    // basic carry chain through nibbles, both requesters
    issue(0, 12'h0FF, 12'h001, 1'b0);
    wait_result(0, 12'h0FF, 12'h001, 1'b0, 1'b1);
    issue(1, 12'hFFF, 12'h000, 1'b1);
    wait_result(1, 12'hFFF, 12'h000, 1'b1, 1'b1);

    // both requesters valid continuously
    s0 = {1'b0, 12'h3A5} + {1'b0, 12'h1C2} + 13'd1;
    s1 = {1'b0, 12'hE10} + {1'b0, 12'h2F7};
    bus.req0_a = 12'h3A5; bus.req0_b = 12'h1C2;
    bus.req0_ci = 1'b1;
    bus.req1_a = 12'hE10; bus.req1_b = 12'h2F7;
    bus.req1_ci = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.res_ready = 1'b1;
    first = 1'b1; lastt = 0; ng = 0;
    for (int cyc = 0; cyc < 32; cyc++) begin
      if (cyc == 22) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      #1;
      if (bus.req0_ready | bus.req1_ready) begin
        g = bus.req1_ready;
`ifdef ADD_SCHED_FIXED_PRIO_EN
        eg = 1'b0;
`else
        eg = ~lg;
`endif
        chk("rr_grant", 32'(g), 32'(eg));
        if (!first) chk("rr_gap", cyc - lastt, 5);
        first = 1'b0; lastt = cyc; lg = g;
        n_acc++; ng++;
        qi.push_back(g);
        qs.push_back(g ? s1 : s0);
      end
      if (bus.res_valid) begin
        n_res++;
        chk("rr_q", 32'(qi.size() > 0), 1);
        if (qi.size() > 0) begin
          chk("rr_id", 32'(bus.res_id), 32'(qi.pop_front()));
          chk("rr_sum", 32'({bus.res_co, bus.res_sum}),
              32'(qs.pop_front()));
        end
      end
      @(negedge clk);
    end
    chk("rr_grants", ng, 5);
    chk("rr_pending", qi.size(), 0);
    bus.res_ready = 1'b0;

    // result held while consumer stalls
    issue(0, 12'h123, 12'h456, 1'b0);
    wait_result(0, 12'h123, 12'h456, 1'b0, 1'b0);
    bus.req1_a = 12'h0F0; bus.req1_b = 12'h00F;
    bus.req1_ci = 1'b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stall_valid", 32'(bus.res_valid), 1);
      chk("stall_sum",
          {bus.res_id, bus.res_co, bus.res_sum}, 32'h579);
      chk("stall_ready",
          {bus.req0_ready, bus.req1_ready}, 0);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    chk("resume_ready", 32'(bus.req1_ready), 1);
    chk("resume_idle", 32'(bus.res_valid), 0);
    @(negedge clk);
    bus.req1_valid = 1'b0;
    lg = 1'b1;
    n_acc++;
    wait_result(1, 12'h0F0, 12'h00F, 1'b1, 1'b1);

    // reset in the middle of an operation
    issue(0, 12'h0AB, 12'h0CD, 1'b0);
    @(negedge clk);
    bus.req0_valid = 1'b1;
    nRES = 1'b0;
    #1;
    chk("ab_valid", 32'(bus.res_valid), 0);
    chk("ab_sum", 32'(bus.res_sum), 0);
    chk("ab_co_id", {bus.res_co, bus.res_id}, 0);
    chk("ab_add", {bus.add_a, bus.add_b, bus.add_ci}, 0);
    chk("ab_ready", {bus.req0_ready, bus.req1_ready}, 0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    nRES = 1'b1;
    lg = 1'b1;
    n_acc--;
    sp = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.res_valid) sp++;
      @(negedge clk);
    end
    chk("ab_no_result", sp, 0);
    issue(0, 12'h800, 12'h800, 1'b0);
    wait_result(0, 12'h800, 12'h800, 1'b0, 1'b1);

    // random sweep, res_ready sometimes held high early
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      bus.res_ready = 1'($urandom_range(0, 1));
      issue(rr, ra, rb, rc);
      wait_result(rr, ra, rb, rc, 1'b1);
    end

    chk("one_result_each", n_res, n_acc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scroll_add_sched.md
# scroll_add_sched

Time-multiplexed sequencer for the 4-bit carry-lookahead adder slice in the tilemap address path. Accepts WIDTH-bit add requests from two requesters (scroll-X and scroll-Y address generators), arbitrates between them, and computes each sum one nibble per clock through a single shared external adder slice, chaining the carry in a register. It sits between the scroll-register logic and the adder cell. It returns the full sum, carry-out and requester ID through a valid/ready handshake.

## Interface
- WIDTH, 12, operand/sum width; must be a multiple of 4, minimum 4; N = WIDTH/4 nibble steps per operation
- clk  in  1  system clock; all state updates on rising edge
- nRES  in  1  reset; asynchronous, active-low
- req0_valid / req1_valid  in  1  request pending
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_ci / req1_ci  in  1  carry-in for bit 0
- add_a, add_b  out  4  nibble operands to the adder slice
- add_ci  out  1  carry-in to the adder slice
- add_s  in  4  slice sum; combinational from add_a/add_b/add_ci, settles within the cycle
- add_co  in  1  slice carry-out
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result when valid&ready
- res_id  out  1  requester ID of the result (0 or 1)
- res_sum  out  WIDTH  sum, modulo 2^WIDTH
- res_co  out  1  carry out of bit WIDTH-1

## Operation
- States: IDLE, RUN, DONE. Registers: operand A/B latches, nibble index k (0..N-1), carry register c, sum register, id, last_grant.
- IDLE: grant is computed combinationally; only the granted requester sees ready=1. Ready is 0 in RUN and DONE.
- Arbitration: round-robin. With one requester valid, that requester is granted. With both valid, the requester not in last_grant is granted. last_grant updates on accept.
- Accept (valid&ready in IDLE): latch operands, latch ci into c, id=granted, k=0, clear sum register, go to RUN.
- RUN, each cycle: drive add_a=A[4k+3:4k], add_b=B[4k+3:4k], add_ci=c. At the edge, write add_s into sum[4k+3:4k], set c=add_co, k++. After step N-1, go to DONE.
- DONE: res_valid=1, and res_sum, res_co (=c) and res_id are held stable. On res_ready go to IDLE.
- Outside RUN, add_a, add_b and add_ci are driven to 0.
- Requesters must hold their operands stable only until the accept edge.

## Timing
- Accept on edge T. Nibbles are captured on edges T+1 … T+N. res_valid rises after edge T+N. Latency = N+1 cycles from accept to the first valid cycle (4 for WIDTH=12).
- Minimum issue interval is N+2 cycles: DONE→IDLE takes one edge, and the next accept can happen in the following cycle.
- res_ready may be held low indefinitely. The result stays stable and requests stay stalled (ready=0).
- Asserting res_ready during IDLE or RUN has no effect.
- Reset values: state=IDLE, k=0, c=0, sum=0, id=0, last_grant=1 (req0 wins the first tie).
- Outputs during nRES low: all *_ready=0, res_valid=0, res_sum=0, res_co=0, res_id=0, add_*=0.
- Reset mid-RUN or mid-DONE aborts the operation. No res_valid is produced and the requester is not re-served automatically.
- Carry wraps: the sum is modulo 2^WIDTH, and res_co captures the overflow.

## Configuration
- ADD_SCHED_FIXED_PRIO_EN defined: fixed priority. req0 is always granted when valid; req1 is granted only when req0_valid=0. last_grant is not used.
- ADD_SCHED_FIXED_PRIO_EN undefined (default): round-robin as above.

## Test plan
- WIDTH=12, req0 a=0x0FF, b=0x001, ci=0 → after 4 cycles res_valid=1, sum=0x100, co=0, id=0. The bench checks that add_a sequences F,F,0 and add_ci sequences 0,1,1.
- req1 a=0xFFF, b=0x000, ci=1 → sum=0x000, co=1, id=1.
- req0 and req1 both valid continuously, res_ready=1 → grants alternate 0,1,0,1 starting with req0. One grant every 5 cycles. With ADD_SCHED_FIXED_PRIO_EN defined, every grant goes to req0.
- res_ready held low 10 cycles after a result (0x123+0x456 → 0x579) → res_* stable, both ready=0 throughout. Accept resumes one cycle after res_ready.
- nRES pulsed low during RUN step 1 → all outputs 0 immediately and no res_valid. A fresh request afterwards completes correctly (0x800+0x800 → sum 0x000, co=1).
- Random operand sweep on both requesters → every result equals a+b+ci against the reference model, and every accepted request yields exactly one result.
